// File: rtl/alu_seq_pipe_pkg.sv
// Shared types for the sequential ALU pipeline: opcode and control-state encodings.
package alu_seq_pipe_pkg;

  typedef enum logic [2:0] {
    OpAdd = 3'd0,
    OpSub = 3'd1,
    OpAnd = 3'd2,
    OpOr  = 3'd3,
    OpXor = 3'd4,
    OpShl = 3'd5,
    OpShr = 3'd6,
    OpMul = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StMulRun = 2'd1,
    StDone   = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module alu_seq_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 last_o,
  output logic [2*WIDTH-1:0]   prod_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [WIDTH:0]     sum;

  // Upper half accumulates, lower half holds the remaining multiplier bits.
  always_comb begin
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    sum     = '0;
    if (start_i) begin
      mcand_d = a_i;
      prod_d  = {{WIDTH{1'b0}}, b_i};
      cnt_d   = CW'(WIDTH - 1);
      busy_d  = 1'b1;
    end else if (busy_q) begin
      sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
      prod_d = {sum, prod_q[WIDTH-1:1]};
      cnt_d  = cnt_q - CW'(1);
      busy_d = (cnt_q != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Final step happens on this edge; prod_o already shows the finished product.
  assign last_o = busy_q && (cnt_q == '0);
  assign prod_o = prod_d;

endmodule

// File: rtl/alu_seq_pipe.sv
// Sequential ALU with valid/ready handshakes, status flags and an iterative multiply.
// Define ALU_SEQ_SAT_EN to make ADD/SUB saturate on signed overflow instead of wrapping.
module alu_seq_pipe
  import alu_seq_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  opcode_e          opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_v
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               c_q, c_d, z_q, z_d, v_q, v_d;

  logic               accept;
  logic               mul_start, mul_last;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH:0]     add_w, sub_w, shl_w, shr_w;
  logic [SHW-1:0]     amt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;

  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (opcode == OpMul);

  alu_seq_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start_i(mul_start),
    .a_i    (operand_a),
    .b_i    (operand_b),
    .last_o (mul_last),
    .prod_o (mul_prod)
  );

  always_comb begin
    amt     = operand_b[SHW-1:0];
    add_w   = {1'b0, operand_a} + {1'b0, operand_b};
    sub_w   = {1'b0, operand_a} - {1'b0, operand_b};
    shl_w   = {1'b0, operand_a} << amt;
    shr_w   = {operand_a, 1'b0} >> amt;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (opcode)
      OpAdd: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                  (add_w[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OpSub: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                  (sub_w[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OpAnd: alu_res = operand_a & operand_b;
      OpOr:  alu_res = operand_a | operand_b;
      OpXor: alu_res = operand_a ^ operand_b;
      OpShl: begin
        alu_res = shl_w[WIDTH-1:0];
        alu_c   = shl_w[WIDTH];
      end
      OpShr: begin
        alu_res = shr_w[WIDTH:1];
        alu_c   = shr_w[0];
      end
      default: alu_res = '0;
    endcase
`ifdef ALU_SEQ_SAT_EN
    // On overflow the true result lies beyond the limit on operand_a's side.
    if (alu_v) begin
      alu_res = operand_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    c_d      = c_q;
    z_d      = z_q;
    v_d      = v_q;
    if (accept) begin
      if (opcode == OpMul) begin
        state_d = StMulRun;
      end else begin
        state_d  = StDone;
        result_d = alu_res;
        hi_d     = '0;
        c_d      = alu_c;
        z_d      = (alu_res == '0);
        v_d      = alu_v;
      end
    end else begin
      case (state_q)
        StMulRun: begin
          if (mul_last) begin
            state_d  = StDone;
            result_d = mul_prod[WIDTH-1:0];
            hi_d     = mul_prod[2*WIDTH-1:WIDTH];
            c_d      = 1'b0;
            z_d      = (mul_prod == '0);
            v_d      = 1'b0;
          end
        end
        StDone: begin
          if (out_ready) state_d = StIdle;
        end
        StIdle:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      result_q <= '0;
      hi_q     <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      c_q      <= c_d;
      z_q      <= z_d;
      v_q      <= v_d;
    end
  end

  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign result_hi = hi_q;
  assign flag_c    = c_q;
  assign flag_z    = z_q;
  assign flag_v    = v_q;

endmodule
